blaster_cmd_encoder: RTL and testbench
======================================

Name: blaster_cmd_encoder

Overview:
- Host-side initiator for the USB-Blaster byte protocol; the counterpart of the blaster handler, which decodes that protocol and drives the JTAG/AS pins.
- Converts JTAG/AS operations (bit-bang clocks, byte shifts, pin updates) into the command byte stream for the UART TX FIFO.
- Matches returning read-back bytes from the UART RX path to the commands that requested them.
- Used for loopback verification of the handler and as a host engine inside bridge FPGAs.

Parameters:
- TAG_DEPTH, 16: read-tag FIFO entries, i.e. the number of read commands that may be outstanding; power of 2.
- PEND_W, 10: width of o_pending.
- TIMEOUT_CLKS, 65535: RX silence limit. Used only when the optional feature is enabled.

Ports:
- i_clk  in  1  primary clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  command accepted when valid&ready.
- i_cmd_op  in  2  0=BITBANG, 1=SHIFT, 2=PINS, 3=reserved.
- i_cmd_tms  in  1  TMS value for BITBANG.
- i_cmd_tdi  in  1  TDI value for BITBANG.
- i_cmd_read  in  1  request TDO/ASDO read-back.
- i_cmd_len  in  6  SHIFT byte count, 1..63.
- i_cmd_pins  in  3  PINS value {oe,ncs,nce}.
- i_data  in  8  SHIFT payload byte.
- i_data_valid  in  1  payload handshake, valid side.
- o_data_ready  out  1  payload handshake, ready side.
- o_tx_byte  out  8  protocol byte toward TX FIFO.
- o_tx_valid  out  1  TX handshake, valid side.
- i_tx_ready  in  1  TX handshake, ready side (i.e. not fifo_full).
- i_rx_byte  in  8  returned byte from RX FIFO.
- i_rx_valid  in  1  one-cycle strobe per returned byte.
- o_rd_data  out  8  read-back data.
- o_rd_valid  out  1  one-cycle strobe.
- o_rd_is_bit  out  1  1 = BITBANG result; TDO is in bit0, bits 7:1 are zero.
- o_pending  out  PEND_W  read-back bytes still expected.
- o_busy  out  1  FSM not in IDLE or o_tx_valid high.
- o_err  out  1  one-cycle error pulse.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; tag FIFO empty.
  - Pin shadow {oe,ncs,nce}=3'b010; tck=tms=tdi=0.
- Protocol byte formats:
  - Bit-bang byte: b7=0, b6=read, b5=oe, b4=tdi, b3=ncs, b2=nce, b1=tms, b0=tck.
  - Shift header: b7=1, b6=read, b5:0=len; followed by len payload bytes, LSB-first on the wire.
- TX output register:
  - o_tx_byte is held stable while o_tx_valid=1 and i_tx_ready=0.
  - A new byte may load in the same cycle the current one is accepted, giving 1 byte/clk throughput.
- o_cmd_ready is high only when all hold: FSM in IDLE, TX register free or being accepted this cycle, and (i_cmd_read=0 or tag FIFO not full).
- FSM states: IDLE, BB_LO, BB_HI, SH_PRE, SH_HDR, SH_DATA, PIN_SET.
- BITBANG path: IDLE->BB_LO->BB_HI->IDLE.
  - BB_LO emits tck=0 with the new tms/tdi and read=i_cmd_read.
  - BB_HI emits tck=1 with read=0.
  - Pin shadow ends with tck=1.
- SHIFT path: IDLE->SH_PRE (only if shadow tck=1)->SH_HDR->SH_DATA->IDLE.
  - SH_PRE emits a bit-bang byte with tck=0 and the shadow tms/tdi, read=0.
  - SH_DATA asserts o_data_ready while the TX register can load.
  - A 6-bit down-counter tracks payload bytes; SH_DATA leaves after byte len.
- PINS path: IDLE->PIN_SET->IDLE. Updates the shadow, then emits one bit-bang byte with the current tck/tms/tdi and read=0.
- Read tracking:
  - Accepting a read command pushes tag {is_bit, count}: BITBANG count=1, SHIFT count=len.
  - o_pending increments by count at accept time.
- Returned bytes:
  - Each i_rx_valid produces o_rd_valid one cycle later (registered, no backpressure).
  - The head tag's is_bit sets o_rd_is_bit and, when set, masks the data to {7'b0, rx[0]}.
  - The head tag's count decrements; the tag pops at 0.
  - o_pending decrements per byte.
  - A tag push and a pop or decrement in the same cycle are both applied.
- Error cases (each pulses o_err for one cycle):
  - Reserved op: command accepted and dropped.
  - SHIFT with len=0: command accepted and dropped.
  - i_rx_valid while the tag FIFO is empty: byte dropped, o_rd_valid stays 0.
- Reset mid-operation: immediate abort, partial SHIFT not completed, tags and o_pending cleared.

Optional Feature:
- Macro: BLASTER_ENC_RX_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while o_pending!=0 and resets on each i_rx_valid.
  - At TIMEOUT_CLKS it flushes the tag FIFO, clears o_pending and pulses o_err.
- Without the macro: no counter; the block waits indefinitely.

Test Plan:
- Reset, then BITBANG tms=1 tdi=0 read=1 with i_tx_ready=1 -> tx bytes 0x4A then 0x0B, o_pending=1. Then i_rx_byte=0xFF -> o_rd_data=0x01, o_rd_is_bit=1, o_pending=0.
- After that BITBANG (tck=1, tms=1), SHIFT read=1 len=3 with payload A5,3C,FF -> tx 0x0A, 0xC3, 0xA5, 0x3C, 0xFF. Rx 11,22,33 -> three o_rd_valid strobes, is_bit=0, o_pending 3->0.
- i_tx_ready toggled 1-0-1 during a SHIFT len=2 write -> o_tx_byte stable while stalled; exactly 0x82 plus 2 payload bytes emitted, none duplicated.
- Accept 16 BITBANG reads with no RX -> o_cmd_ready=0 for a 17th read while a read=0 command is still accepted. Return 1 byte -> read accepted again.
- i_rx_valid with o_pending=0, and SHIFT len=0 -> o_err pulses, no o_rd_valid, no tx byte.
- Reset asserted during SH_DATA of len=5 after 2 payload bytes -> o_tx_valid=0 and o_pending=0 immediately; the next BITBANG emits 0x08/0x09.

Source files
------------

// File: rtl/blaster_cmd_encoder.sv
// blaster_cmd_encoder
// Host-side initiator for the USB-Blaster byte protocol. Turns bit-bang,
// byte-shift and pin-update operations into the command byte stream for a
// UART TX FIFO, and pairs returning RX bytes with the read commands that
// requested them through a small tag FIFO.
//
// Optional feature: define BLASTER_ENC_RX_TIMEOUT_EN to enable the RX
// silence watchdog (TIMEOUT_CLKS), which flushes outstanding read tags.
//
// Handshakes: every valid/ready pair transfers on a rising clock edge where
// both are high; valid, once raised, holds its payload until that transfer.
// i_rx_valid is a strobe with no backpressure.
//
// FSM state is exposed as o_dbg_state for checkers.

module blaster_cmd_encoder #(
    parameter int TAG_DEPTH    = 16,
    parameter int PEND_W       = 10,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic              i_cmd_tms,
    input  logic              i_cmd_tdi,
    input  logic              i_cmd_read,
    input  logic [5:0]        i_cmd_len,
    input  logic [2:0]        i_cmd_pins,
    input  logic [7:0]        i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rx_valid,
    output logic [7:0]        o_rd_data,
    output logic              o_rd_valid,
    output logic              o_rd_is_bit,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_busy,
    output logic              o_err,
    output logic [2:0]        o_dbg_state
);

    localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BB_LO   = 3'd1;
    localparam logic [2:0] S_BB_HI   = 3'd2;
    localparam logic [2:0] S_SH_PRE  = 3'd3;
    localparam logic [2:0] S_SH_HDR  = 3'd4;
    localparam logic [2:0] S_SH_DATA = 3'd5;
    localparam logic [2:0] S_PIN_SET = 3'd6;

    localparam logic [1:0] OP_BITBANG = 2'd0;
    localparam logic [1:0] OP_SHIFT   = 2'd1;
    localparam logic [1:0] OP_PINS    = 2'd2;

    // FSM and TX register
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_tx_byte;
    logic [7:0] w_tx_nxt;
    logic       r_tx_valid;
    logic       w_tx_load;
    logic       w_tx_free;

    // Pin shadow: what the handler's pins currently hold
    logic r_oe;
    logic r_ncs;
    logic r_nce;
    logic r_tck;
    logic r_tms;
    logic r_tdi;

    // Latched command fields; r_len doubles as the payload down-counter
    logic       r_c_read;
    logic [5:0] r_len;

    logic       w_cmd_acc;
    logic       w_push;
    logic       w_push_bit;
    logic [5:0] w_push_cnt;
    logic       w_err_cmd;

    // Read-tag FIFO
    logic                r_tag_bit [TAG_DEPTH];
    logic [5:0]          r_tag_cnt [TAG_DEPTH];
    logic [TAG_AW-1:0]   r_wr_ptr;
    logic [TAG_AW-1:0]   r_rd_ptr;
    logic [TAG_AW:0]     r_tag_count;
    logic                w_tag_full;
    logic                w_tag_empty;
    logic                w_rx_hit;
    logic                w_rx_miss;
    logic                w_head_last;
    logic                w_pop;
    logic                w_timeout;

    logic [PEND_W-1:0] r_pending;
    logic [7:0]        r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_is_bit;
    logic              r_err;

    assign w_tx_free   = !r_tx_valid || i_tx_ready;
    assign w_tag_full  = (r_tag_count == (TAG_AW+1)'(TAG_DEPTH));
    assign w_tag_empty = (r_tag_count == '0);
    assign o_cmd_ready = (r_state == S_IDLE) && w_tx_free && (!i_cmd_read || !w_tag_full);
    assign w_cmd_acc   = i_cmd_valid && o_cmd_ready;
    assign o_data_ready = (r_state == S_SH_DATA) && w_tx_free;

    assign w_rx_hit    = i_rx_valid && !w_tag_empty;
    assign w_rx_miss   = i_rx_valid && w_tag_empty;
    assign w_head_last = (r_tag_cnt[r_rd_ptr] == 6'd1);
    assign w_pop       = w_rx_hit && w_head_last;

    // Next state, TX byte to load, tag push and command error decode
    always_comb begin
        w_state_nxt = r_state;
        w_tx_load   = 1'b0;
        w_tx_nxt    = r_tx_byte;
        w_push      = 1'b0;
        w_push_bit  = 1'b0;
        w_push_cnt  = 6'd0;
        w_err_cmd   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_acc) begin
                    case (i_cmd_op)
                        OP_BITBANG: begin
                            w_state_nxt = S_BB_LO;
                            w_push      = i_cmd_read;
                            w_push_bit  = 1'b1;
                            w_push_cnt  = i_cmd_read ? 6'd1 : 6'd0;
                        end
                        OP_SHIFT: begin
                            if (i_cmd_len == 6'd0) begin
                                w_err_cmd = 1'b1;
                            end else begin
                                // A shift must start from TCK low
                                w_state_nxt = r_tck ? S_SH_PRE : S_SH_HDR;
                                w_push      = i_cmd_read;
                                w_push_cnt  = i_cmd_read ? i_cmd_len : 6'd0;
                            end
                        end
                        OP_PINS: w_state_nxt = S_PIN_SET;
                        default: w_err_cmd = 1'b1;
                    endcase
                end
            end
            S_BB_LO: begin
                if (w_tx_free) begin
                    w_tx_load   = 1'b1;
                    w_tx_nxt    = {1'b0, r_c_read, r_oe, r_tdi, r_ncs, r_nce, r_tms, 1'b0};
                    w_state_nxt = S_BB_HI;
                end
            end
            S_BB_HI: begin
                if (w_tx_free) begin
                    w_tx_load   = 1'b1;
                    w_tx_nxt    = {1'b0, 1'b0, r_oe, r_tdi, r_ncs, r_nce, r_tms, 1'b1};
                    w_state_nxt = S_IDLE;
                end
            end
            S_SH_PRE: begin
                if (w_tx_free) begin
                    w_tx_load   = 1'b1;
                    w_tx_nxt    = {1'b0, 1'b0, r_oe, r_tdi, r_ncs, r_nce, r_tms, 1'b0};
                    w_state_nxt = S_SH_HDR;
                end
            end
            S_SH_HDR: begin
                if (w_tx_free) begin
                    w_tx_load   = 1'b1;
                    w_tx_nxt    = {1'b1, r_c_read, r_len};
                    w_state_nxt = S_SH_DATA;
                end
            end
            S_SH_DATA: begin
                if (o_data_ready && i_data_valid) begin
                    w_tx_load = 1'b1;
                    w_tx_nxt  = i_data;
                    if (r_len == 6'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_PIN_SET: begin
                if (w_tx_free) begin
                    w_tx_load   = 1'b1;
                    w_tx_nxt    = {1'b0, 1'b0, r_oe, r_tdi, r_ncs, r_nce, r_tms, r_tck};
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, TX register, latched command fields and pin shadow
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_tx_byte  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_oe       <= 1'b0;
            r_ncs      <= 1'b1;
            r_nce      <= 1'b0;
            r_tck      <= 1'b0;
            r_tms      <= 1'b0;
            r_tdi      <= 1'b0;
            r_c_read   <= 1'b0;
            r_len      <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tx_load) begin
                r_tx_byte  <= w_tx_nxt;
                r_tx_valid <= 1'b1;
            end else if (i_tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            if (w_cmd_acc) begin
                r_c_read <= i_cmd_read;
                r_len    <= i_cmd_len;
                if (i_cmd_op == OP_BITBANG) begin
                    r_tms <= i_cmd_tms;
                    r_tdi <= i_cmd_tdi;
                end
                if (i_cmd_op == OP_PINS) begin
                    {r_oe, r_ncs, r_nce} <= i_cmd_pins;
                end
            end
            if (w_tx_load) begin
                case (r_state)
                    S_BB_LO, S_SH_PRE: r_tck <= 1'b0;
                    S_BB_HI:           r_tck <= 1'b1;
                    S_SH_DATA:         r_len <= r_len - 6'd1;
                    default: ;
                endcase
            end
        end
    end

`ifdef BLASTER_ENC_RX_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS + 1) : 1;
    logic [TO_W-1:0] r_to_cnt;

    // Count idle clocks while read-back bytes are outstanding
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_to_cnt <= '0;
        end else if (i_rx_valid || (r_pending == '0) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CLKS)) && !i_rx_valid;
`else
    // Without the watchdog the encoder waits indefinitely; the parameter is
    // kept so both builds share one instantiation, and this is never true.
    assign w_timeout = (TIMEOUT_CLKS < 0);
`endif

    // Tag storage: written on push, head count decremented per returned byte
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_tag_bit[r_wr_ptr] <= w_push_bit;
            r_tag_cnt[r_wr_ptr] <= w_push_cnt;
        end
        if (w_rx_hit && !w_head_last) begin
            r_tag_cnt[r_rd_ptr] <= r_tag_cnt[r_rd_ptr] - 6'd1;
        end
    end

    // Tag pointers, occupancy and outstanding byte count
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tag_count <= '0;
            r_pending   <= '0;
        end else if (w_timeout) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tag_count <= '0;
            r_pending   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_tag_count <= r_tag_count + (TAG_AW+1)'(w_push) - (TAG_AW+1)'(w_pop);
            r_pending   <= r_pending + PEND_W'(w_push_cnt) - PEND_W'(w_rx_hit);
        end
    end

    // Registered read-back output and error pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_data   <= 8'd0;
            r_rd_valid  <= 1'b0;
            r_rd_is_bit <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rd_valid <= w_rx_hit;
            if (w_rx_hit) begin
                r_rd_is_bit <= r_tag_bit[r_rd_ptr];
                r_rd_data   <= r_tag_bit[r_rd_ptr] ? {7'd0, i_rx_byte[0]} : i_rx_byte;
            end
            r_err <= w_err_cmd || w_rx_miss || w_timeout;
        end
    end

    assign o_tx_byte   = r_tx_byte;
    assign o_tx_valid  = r_tx_valid;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_is_bit = r_rd_is_bit;
    assign o_pending   = r_pending;
    assign o_busy      = (r_state != S_IDLE) || r_tx_valid;
    assign o_err       = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_blaster_cmd_encoder.sv
// Self-checking bench for blaster_cmd_encoder: directed scenarios followed by
// a randomized command/read-back mix, checked against a byte-level model.

module tb_blaster_cmd_encoder;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_op = 2'd0;
  logic       i_cmd_tms = 1'b0;
  logic       i_cmd_tdi = 1'b0;
  logic       i_cmd_read = 1'b0;
  logic [5:0] i_cmd_len = 6'd0;
  logic [2:0] i_cmd_pins = 3'd0;
  logic [7:0] i_data = 8'd0;
  logic       i_data_valid = 1'b0;
  logic       o_data_ready;
  logic [7:0] o_tx_byte;
  logic       o_tx_valid;
  logic       i_tx_ready = 1'b1;
  logic [7:0] i_rx_byte = 8'd0;
  logic       i_rx_valid = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       o_rd_is_bit;
  logic [9:0] o_pending;
  logic       o_busy;
  logic       o_err;
  logic [2:0] o_dbg_state;

  always #5 i_clk = ~i_clk;

  blaster_cmd_encoder dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_cmd_tms(i_cmd_tms), .i_cmd_tdi(i_cmd_tdi), .i_cmd_read(i_cmd_read),
    .i_cmd_len(i_cmd_len), .i_cmd_pins(i_cmd_pins),
    .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
    .o_tx_byte(o_tx_byte), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .i_rx_byte(i_rx_byte), .i_rx_valid(i_rx_valid),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_is_bit(o_rd_is_bit),
    .o_pending(o_pending), .o_busy(o_busy), .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // scoreboard and model state
  logic [7:0] exp_q[$];
  int tq_cnt[$];
  int tq_bit[$];
  int m_pending;
  int m_oe, m_ncs, m_nce, m_tck, m_tms, m_tdi;
  int rd_exp_total = 0;
  int err_exp_total = 0;
  int rd_seen = 0;
  int err_seen = 0;
  int rdy_mode = 0;
  int exp_err_now;
  logic [7:0] pl[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bb(input int rd, input int oe, input int tdi, input int ncs,
                                    input int nce, input int tms, input int tck);
    return 8'(rd * 64 + oe * 32 + tdi * 16 + ncs * 8 + nce * 4 + tms * 2 + tck);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    tq_cnt.delete();
    tq_bit.delete();
    m_pending = 0;
    m_oe = 0; m_ncs = 1; m_nce = 0;
    m_tck = 0; m_tms = 0; m_tdi = 0;
  endtask

  task automatic model_accept(input int op, input int tms, input int tdi, input int rd,
                              input int len, input int pins);
    exp_err_now = 0;
    case (op)
      0: begin
        m_tms = tms; m_tdi = tdi;
        exp_q.push_back(bb(rd, m_oe, m_tdi, m_ncs, m_nce, m_tms, 0));
        exp_q.push_back(bb(0, m_oe, m_tdi, m_ncs, m_nce, m_tms, 1));
        m_tck = 1;
        if (rd != 0) begin
          tq_cnt.push_back(1); tq_bit.push_back(1); m_pending += 1;
        end
      end
      1: begin
        if (len == 0) begin
          exp_err_now = 1;
        end else begin
          if (m_tck != 0) begin
            exp_q.push_back(bb(0, m_oe, m_tdi, m_ncs, m_nce, m_tms, 0));
            m_tck = 0;
          end
          exp_q.push_back(8'(128 + rd * 64 + len));
          for (int i = 0; i < len; i++) exp_q.push_back(pl[i]);
          if (rd != 0) begin
            tq_cnt.push_back(len); tq_bit.push_back(0); m_pending += len;
          end
        end
      end
      2: begin
        m_oe = (pins / 4) % 2; m_ncs = (pins / 2) % 2; m_nce = pins % 2;
        exp_q.push_back(bb(0, m_oe, m_tdi, m_ncs, m_nce, m_tms, m_tck));
      end
      default: exp_err_now = 1;
    endcase
    if (exp_err_now != 0) err_exp_total++;
  endtask

  // TX monitor: every visible byte must be the scoreboard head; it leaves the
  // queue only when the sink is ready.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_rd_valid === 1'b1) rd_seen++;
      if (o_err === 1'b1) err_seen++;
      if (o_tx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("tx_unexpected_valid", o_tx_valid, 0);
        end else begin
          chk("tx_byte", o_tx_byte, exp_q[0]);
          if (i_tx_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // randomized TX backpressure when enabled
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rdy_mode == 1) i_tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // all driver tasks start and end at posedge+1
  task automatic do_cmd(input int op, input int tms, input int tdi, input int rd,
                        input int len, input int pins);
    bit ok;
    i_cmd_valid = 1'b1;
    i_cmd_op = 2'(op); i_cmd_tms = 1'(tms); i_cmd_tdi = 1'(tdi);
    i_cmd_read = 1'(rd); i_cmd_len = 6'(len); i_cmd_pins = 3'(pins);
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_clk);
      if (o_cmd_ready === 1'b1) begin ok = 1; break; end
      @(posedge i_clk); #1;
    end
    if (!ok) begin
      chk("cmd_ready_timeout", o_cmd_ready, 1);
      i_cmd_valid = 1'b0;
      return;
    end
    @(posedge i_clk);
    model_accept(op, tms, tdi, rd, len, pins);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd_read = 1'b0;
    @(negedge i_clk);
    chk("cmd_err", o_err, 32'(exp_err_now));
    chk("pending_after_cmd", o_pending, 32'(m_pending));
    @(posedge i_clk); #1;
  endtask

  task automatic send_payload(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      i_data = pl[i];
      i_data_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge i_clk);
        if (o_data_ready === 1'b1) begin ok = 1; break; end
        @(posedge i_clk); #1;
      end
      if (!ok) chk("data_ready_timeout", o_data_ready, 1);
      @(posedge i_clk); #1;
      i_data_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin @(posedge i_clk); #1; end
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    int exp_v, exp_bit, exp_miss;
    logic [7:0] exp_d;
    i_rx_byte = b;
    i_rx_valid = 1'b1;
    exp_d = 8'd0; exp_bit = 0;
    if (tq_cnt.size() == 0) begin
      exp_v = 0; exp_miss = 1; err_exp_total++;
    end else begin
      exp_v = 1; exp_miss = 0; rd_exp_total++;
      exp_bit = tq_bit[0];
      exp_d = (exp_bit != 0) ? 8'(b % 2) : b;
      tq_cnt[0] = tq_cnt[0] - 1;
      if (tq_cnt[0] == 0) begin
        void'(tq_cnt.pop_front()); void'(tq_bit.pop_front());
      end
      m_pending -= 1;
    end
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    chk("rd_valid", o_rd_valid, 32'(exp_v));
    if (exp_v != 0) begin
      chk("rd_data", o_rd_data, exp_d);
      chk("rd_is_bit", o_rd_is_bit, 32'(exp_bit));
    end
    chk("rx_err", o_err, 32'(exp_miss));
    chk("pending_after_rx", o_pending, 32'(m_pending));
    @(posedge i_clk); #1;
  endtask

  task automatic drain_tx();
    bit ok;
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      if (exp_q.size() == 0 && o_busy === 1'b0) begin ok = 1; break; end
      @(posedge i_clk); #1;
    end
    chk("drain_done", 32'(ok), 1);
  endtask

  initial begin
    int op, len, rd;
    model_reset();
    #1 i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("reset_tx_valid", o_tx_valid, 0);
    chk("reset_rd_valid", o_rd_valid, 0);
    chk("reset_pending", o_pending, 0);
    chk("reset_err", o_err, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_data_ready", o_data_ready, 0);
    @(posedge i_clk); #1;

    // bit-bang read: 0x4A, 0x0B, then masked read-back
    do_cmd(0, 1, 0, 1, 0, 0);
    drain_tx();
    send_rx(8'hFF);

    // bit-bang leaving tck=1, then SHIFT read len=3 with pre-clock byte
    do_cmd(0, 1, 0, 0, 0, 0);
    pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'hFF;
    do_cmd(1, 0, 0, 1, 3, 0);
    send_payload(3);
    drain_tx();
    send_rx(8'h11);
    send_rx(8'h22);
    send_rx(8'h33);

    // stalled header during SHIFT len=2 write
    pl[0] = 8'($urandom_range(0, 255)); pl[1] = 8'($urandom_range(0, 255));
    do_cmd(1, 0, 0, 0, 2, 0);
    i_tx_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_tx_ready = 1'b1;
    send_payload(2);
    drain_tx();

    // fill the tag FIFO
    for (int i = 0; i < 16; i++) begin
      do_cmd(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1, 0, 0);
    end
    drain_tx();
    i_cmd_op = 2'd0; i_cmd_read = 1'b1; i_cmd_valid = 1'b1;
    @(negedge i_clk);
    chk("ready_tags_full", o_cmd_ready, 0);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0; i_cmd_read = 1'b0;
    @(negedge i_clk);
    chk("ready_full_no_read", o_cmd_ready, 1);
    @(posedge i_clk); #1;
    do_cmd(2, 0, 0, 0, 0, 5);
    drain_tx();
    send_rx(8'($urandom_range(0, 255)));
    i_cmd_read = 1'b1;
    @(negedge i_clk);
    chk("ready_after_pop", o_cmd_ready, 1);
    @(posedge i_clk); #1;
    i_cmd_read = 1'b0;
    while (tq_cnt.size() > 0) send_rx(8'($urandom_range(0, 255)));

    // error cases
    send_rx(8'h5A);
    do_cmd(1, 0, 0, 0, 0, 0);
    do_cmd(3, 0, 0, 1, 0, 0);
    drain_tx();

    // restore default pins, then reset in the middle of a SHIFT payload
    do_cmd(2, 0, 0, 0, 0, 2);
    for (int i = 0; i < 5; i++) pl[i] = 8'($urandom_range(0, 255));
    do_cmd(1, 0, 0, 1, 5, 0);
    send_payload(2);
    i_reset = 1'b1;
    model_reset();
    #1;
    chk("midreset_tx_valid", o_tx_valid, 0);
    chk("midreset_pending", o_pending, 0);
    chk("midreset_busy", o_busy, 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    do_cmd(0, 0, 0, 0, 0, 0);
    drain_tx();
    send_rx(8'h77);

    // randomized mix
    rdy_mode = 1;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_rx(8'($urandom_range(0, 255)));
      end else begin
        op = int'($urandom_range(0, 3));
        len = int'($urandom_range(0, 6));
        rd = int'($urandom_range(0, 1));
        if (tq_cnt.size() >= 16) rd = 0;
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
        do_cmd(op, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), rd, len,
               int'($urandom_range(0, 7)));
        if (op == 1 && len > 0) send_payload(len);
      end
    end
    rdy_mode = 0;
    @(posedge i_clk); #1;
    i_tx_ready = 1'b1;
    drain_tx();
    while (tq_cnt.size() > 0) send_rx(8'($urandom_range(0, 255)));
    repeat (2) @(posedge i_clk);
    #1;
    chk("rd_strobe_total", 32'(rd_seen), 32'(rd_exp_total));
    chk("err_pulse_total", 32'(err_seen), 32'(err_exp_total));
    chk("final_pending", o_pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
